// File: rtl/memory_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline: issues dbus requests for LW/SW,
// waits for completion and presents a registered MEM->WB record.
module memory_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  input  logic        in_mem_to_reg,
  input  logic        in_mem_write,
  input  logic        in_reg_write,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_store_data,
  output logic        dreq_valid,
  output logic [31:0] dreq_addr,
  output logic [3:0]  dreq_strobe,
  output logic [31:0] dreq_data,
  input  logic        dreq_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [31:0] dresp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_reg_write,
  output logic [4:0]  out_rd,
  output logic [31:0] out_wdata,
  output logic        out_exc,
  output logic        out_timeout
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

  state_t      state, state_nxt;
  logic [31:0] pc_q, instr_q, addr_q, sdata_q, wdata_q;
  logic        m2r_q, mw_q, rw_q, exc_q, timeout_q;
  logic [4:0]  rd_q;
  logic [7:0]  cnt, cnt_inc;
  logic        accept, in_mem, in_exc, busy, stay;

  assign in_mem  = in_mem_to_reg | in_mem_write;
  assign in_exc  = in_mem & (|in_alu_result[1:0]);
  assign accept  = in_valid & in_ready;
  assign busy    = (state == REQ) | (state == WAIT);
  assign stay    = busy & ((state_nxt == REQ) | (state_nxt == WAIT));
  assign cnt_inc = (cnt == 8'hff) ? cnt : cnt + 8'd1;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      REQ:  if (dreq_addr_ok) state_nxt = dresp_data_ok ? HOLD : WAIT;
      WAIT: if (dresp_data_ok) state_nxt = HOLD;
      HOLD: if (out_ready) begin
        in_ready  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Misaligned or non-memory ops skip the bus entirely.
    if (accept) state_nxt = (in_mem && !in_exc) ? REQ : HOLD;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pc_q      <= '0;
      instr_q   <= '0;
      addr_q    <= '0;
      sdata_q   <= '0;
      wdata_q   <= '0;
      m2r_q     <= 1'b0;
      mw_q      <= 1'b0;
      rw_q      <= 1'b0;
      exc_q     <= 1'b0;
      rd_q      <= '0;
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        pc_q    <= in_pc;
        instr_q <= in_instr;
        addr_q  <= {in_alu_result[31:2], 2'b00};
        sdata_q <= in_store_data;
        wdata_q <= in_alu_result;
        m2r_q   <= in_mem_to_reg;
        mw_q    <= in_mem_write;
        rw_q    <= in_reg_write;
        exc_q   <= in_exc;
        rd_q    <= in_rd;
      end else if (busy && state_nxt == HOLD && m2r_q) begin
        wdata_q <= dresp_data;
      end
      cnt <= stay ? cnt_inc : 8'd0;
      // Timeout only flags; the transaction is still allowed to finish.
      if (stay && TO_LIMIT != 8'd0 && cnt_inc == TO_LIMIT) timeout_q <= 1'b1;
    end
  end

  assign dreq_valid    = (state == REQ);
  assign dreq_addr     = addr_q;
  assign dreq_strobe   = {4{mw_q}};
  assign dreq_data     = sdata_q;
  assign out_valid     = (state == HOLD);
  assign out_pc        = pc_q;
  assign out_instr     = instr_q;
  assign out_reg_write = rw_q & ~exc_q;
  assign out_rd        = rd_q;
  assign out_wdata     = wdata_q;
  assign out_exc       = exc_q;
  assign out_timeout   = timeout_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: program-order scoreboard of WB
// records and dbus requests, a delay-programmable bus responder, literal pins.
module tb_memory_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_instr, in_alu_result, in_store_data;
  logic        in_mem_to_reg, in_mem_write, in_reg_write;
  logic [4:0]  in_rd;
  logic        dreq_valid;
  logic [31:0] dreq_addr, dreq_data;
  logic [3:0]  dreq_strobe;
  logic        dreq_addr_ok = 1'b0, dresp_data_ok = 1'b0;
  logic [31:0] dresp_data = 32'h0;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_instr, out_wdata;
  logic        out_reg_write, out_exc, out_timeout;
  logic [4:0]  out_rd;

  always #5 clk = ~clk;

  memory_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr),
    .in_mem_to_reg(in_mem_to_reg), .in_mem_write(in_mem_write),
    .in_reg_write(in_reg_write), .in_rd(in_rd),
    .in_alu_result(in_alu_result), .in_store_data(in_store_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_strobe(dreq_strobe),
    .dreq_data(dreq_data), .dreq_addr_ok(dreq_addr_ok),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_reg_write(out_reg_write),
    .out_rd(out_rd), .out_wdata(out_wdata), .out_exc(out_exc),
    .out_timeout(out_timeout)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a == 32'h100) ? 32'hdeadbeef : {a[15:0], 16'hc0de};
  endfunction

  // ---------------- bus responder ----------------
  logic [31:0] bus_mem [logic [31:0]];
  int          ok_dly = 0, data_dly = 0;
  bit          never_ok = 0;
  int          req_age = 0, wait_age = 0;
  bit          in_wait = 0;
  logic [31:0] r_addr, r_data;
  logic        r_wr;

  task automatic respond();
    dresp_data_ok = 1'b1;
    in_wait = 0;
    if (r_wr) bus_mem[r_addr] = r_data;
    else dresp_data = bus_mem.exists(r_addr) ? bus_mem[r_addr] : init_word(r_addr);
  endtask

  always @(posedge clk) begin
    #1;
    dreq_addr_ok  = 1'b0;
    dresp_data_ok = 1'b0;
    if (in_wait) begin
      wait_age++;
      if (wait_age >= data_dly) respond();
    end else if (dreq_valid && !reset && !never_ok) begin
      if (req_age >= ok_dly) begin
        dreq_addr_ok = 1'b1;
        req_age = 0;
        r_addr = dreq_addr;
        r_data = dreq_data;
        r_wr   = (dreq_strobe != 4'h0);
        if (data_dly == 0) respond();
        else begin
          in_wait  = 1;
          wait_age = 0;
        end
      end else req_age++;
    end
  end

  // ---------------- program-order model + compare ----------------
  typedef struct {
    logic [31:0] pc, instr, wdata;
    logic        rw, exc;
    logic [4:0]  rd;
  } wb_t;
  typedef struct {
    logic [31:0] addr, data;
    logic        wr;
  } rq_t;

  wb_t         wbq[$];
  rq_t         rqq[$];
  logic [31:0] exp_mem [logic [31:0]];

  always @(negedge clk) begin
    if (reset) begin
      wbq.delete();
      rqq.delete();
    end else begin
      if (dreq_valid) begin
        if (rqq.size() == 0) chk("unexpected_dreq", dreq_valid, 0);
        else begin
          chk("m_dreq_addr", dreq_addr, rqq[0].addr);
          chk("m_dreq_strobe", dreq_strobe, rqq[0].wr ? 32'hf : 32'h0);
          if (rqq[0].wr) chk("m_dreq_data", dreq_data, rqq[0].data);
          if (dreq_addr_ok) void'(rqq.pop_front());
        end
      end
      if (out_valid) begin
        if (wbq.size() == 0) chk("unexpected_out", out_valid, 0);
        else begin
          chk("m_out_pc", out_pc, wbq[0].pc);
          chk("m_out_instr", out_instr, wbq[0].instr);
          chk("m_out_wdata", out_wdata, wbq[0].wdata);
          chk("m_out_rd", out_rd, wbq[0].rd);
          chk("m_out_rw", out_reg_write, wbq[0].rw);
          chk("m_out_exc", out_exc, wbq[0].exc);
          if (out_ready) void'(wbq.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        wb_t w;
        rq_t r;
        logic mem;
        mem     = in_mem_to_reg | in_mem_write;
        w.pc    = in_pc;
        w.instr = in_instr;
        w.rd    = in_rd;
        w.exc   = mem && (in_alu_result[1:0] != 2'b00);
        w.rw    = in_reg_write && !w.exc;
        w.wdata = in_alu_result;
        if (in_mem_to_reg && !w.exc)
          w.wdata = exp_mem.exists(in_alu_result) ? exp_mem[in_alu_result] : init_word(in_alu_result);
        if (in_mem_write && !w.exc) exp_mem[in_alu_result] = in_store_data;
        wbq.push_back(w);
        if (mem && !w.exc) begin
          r.addr = in_alu_result;
          r.data = in_store_data;
          r.wr   = in_mem_write;
          rqq.push_back(r);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] pc, input logic [31:0] instr,
                      input logic m2r, input logic mw, input logic rw,
                      input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] sd);
    int   n;
    logic acc;
    n = 0;
    in_pc = pc; in_instr = instr; in_mem_to_reg = m2r; in_mem_write = mw;
    in_reg_write = rw; in_rd = rd; in_alu_result = alu; in_store_data = sd;
    in_valid = 1'b1;
    do begin
      acc = in_ready;
      tick();
      n++;
    end while (!acc && n < 20);
    in_valid = 1'b0;
    chk("send_accept", acc, 1);
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("wait_out_bound", out_valid, 1);
  endtask

  initial begin
    int n;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_instr = '0; in_mem_to_reg = 1'b0; in_mem_write = 1'b0;
    in_reg_write = 1'b0; in_rd = '0; in_alu_result = '0; in_store_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dreq_valid", dreq_valid, 0);
    chk("rst_timeout", out_timeout, 0);
    chk("rst_wdata", out_wdata, 0);
    chk("rst_in_ready", in_ready, 1);
    reset = 1'b0;
    tick();

    // ALU pass-through, latency 1
    send(32'h400, 32'h00a62020, 0, 0, 1, 5, 32'h1234, 0);
    chk("add_out_valid", out_valid, 1);
    chk("add_wdata", out_wdata, 32'h1234);
    chk("add_rd", out_rd, 5);
    chk("add_no_dreq", dreq_valid, 0);
    tick();
    chk("add_drained", out_valid, 0);

    // LW 0x100, addr_ok one cycle after request, data_ok three after
    ok_dly = 1; data_dly = 2;
    send(32'h404, 32'h8c020100, 1, 0, 1, 2, 32'h100, 0);
    chk("lw_dreq_valid", dreq_valid, 1);
    chk("lw_dreq_addr", dreq_addr, 32'h100);
    chk("lw_strobe", dreq_strobe, 0);
    wait_out(n);
    chk("lw_latency", n, 4);
    chk("lw_wdata", out_wdata, 32'hdeadbeef);
    chk("lw_rw", out_reg_write, 1);
    tick();

    // SW 0x204 with addr_ok and data_ok together
    ok_dly = 0; data_dly = 0;
    send(32'h408, 32'hac050204, 0, 1, 0, 0, 32'h204, 32'h55);
    chk("sw_strobe", dreq_strobe, 32'hf);
    chk("sw_data", dreq_data, 32'h55);
    chk("sw_addr", dreq_addr, 32'h204);
    tick();
    chk("sw_hold_next", out_valid, 1);
    tick();

    // misaligned LW
    send(32'h40c, 32'h8c030102, 1, 0, 1, 3, 32'h102, 0);
    chk("exc_out_valid", out_valid, 1);
    chk("exc_flag", out_exc, 1);
    chk("exc_rw", out_reg_write, 0);
    chk("exc_no_dreq", dreq_valid, 0);
    tick();

    // LW reading back the SW, stalled in HOLD, then back-to-back ADD
    out_ready = 1'b0; data_dly = 1;
    send(32'h410, 32'h8c040204, 1, 0, 1, 4, 32'h204, 0);
    wait_out(n);
    in_pc = 32'h500; in_instr = 32'h01094820; in_mem_to_reg = 1'b0; in_mem_write = 1'b0;
    in_reg_write = 1'b1; in_rd = 9; in_alu_result = 32'h77; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_in_ready", in_ready, 0);
      chk("stall_wdata", out_wdata, 32'h55);
      chk("stall_pc", out_pc, 32'h410);
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("b2b_valid", out_valid, 1);
    chk("b2b_pc", out_pc, 32'h500);
    chk("b2b_wdata", out_wdata, 32'h77);
    tick();
    chk("b2b_drained", out_valid, 0);

    // timeout: addr_ok never comes
    never_ok = 1;
    send(32'h414, 32'h8c050300, 1, 0, 1, 5, 32'h300, 0);
    repeat (3) tick();
    chk("to_not_yet", out_timeout, 0);
    tick();
    chk("to_set", out_timeout, 1);
    chk("to_still_req", dreq_valid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0; never_ok = 0;
    chk("to_cleared", out_timeout, 0);
    chk("to_rst_idle", in_ready, 1);
    chk("to_rst_dreq", dreq_valid, 0);

    // reset while in WAIT, response arrives afterwards
    ok_dly = 0; data_dly = 3;
    send(32'h418, 32'h8c060108, 1, 0, 1, 6, 32'h108, 0);
    tick();
    chk("rw_in_wait", dreq_valid, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rw_no_out", out_valid, 0);
      chk("rw_no_dreq", dreq_valid, 0);
      tick();
    end

    // normal operation resumes
    data_dly = 0;
    send(32'h41c, 32'h00000000, 0, 0, 1, 3, 32'habc, 0);
    chk("resume_wdata", out_wdata, 32'habc);
    tick();
    chk("wbq_empty", wbq.size(), 0);
    chk("rqq_empty", rqq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
